// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, shifter, ALU and branch target.
// Flags feed back to ID; results are registered into EX/MEM.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [3:0]  exe_cmd,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic        wb_en,
  input  logic        imm,
  input  logic        s,
  input  logic        b,
  input  logic [3:0]  dest,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [31:0] pc,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm,
  input  logic [1:0]  fwd_sel1,
  input  logic [1:0]  fwd_sel2,
  input  logic [31:0] mem_fwd_val,
  input  logic [31:0] wb_fwd_val,
  output logic [3:0]  status,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [31:0] alu_res_out,
  output logic [31:0] st_val_out,
  output logic [3:0]  dest_out,
  output logic        wb_en_out,
  output logic        mem_r_out,
  output logic        mem_w_out
);

  function automatic logic [31:0] ror32(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic [31:0] op_a, rm_f, val2, sh_res, add_b, res;
  logic [32:0] sum;
  logic [3:0]  op, flags;
  logic        mem_op, arith, sub_op, ci;

  logic [3:0]  status_q, status_d;
  logic [31:0] alu_q, alu_d, st_q, st_d;
  logic [3:0]  dest_q, dest_d;
  logic        wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;

  assign mem_op = mem_r | mem_w;

  always_comb begin
    unique case (fwd_sel1)
      2'b01:   op_a = mem_fwd_val;
      2'b10:   op_a = wb_fwd_val;
      default: op_a = val_rn;
    endcase
    unique case (fwd_sel2)
      2'b01:   rm_f = mem_fwd_val;
      2'b10:   rm_f = wb_fwd_val;
      default: rm_f = val_rm;
    endcase
  end

  always_comb begin
    unique case (shift_operand[6:5])
      2'b00:   sh_res = rm_f << shift_operand[11:7];
      2'b01:   sh_res = rm_f >> shift_operand[11:7];
      2'b10:   sh_res = $signed(rm_f) >>> shift_operand[11:7];
      default: sh_res = ror32(rm_f, shift_operand[11:7]);
    endcase
    if (mem_op)
      val2 = {20'b0, shift_operand};
    else if (imm)
      val2 = ror32({24'b0, shift_operand[7:0]},
                   {shift_operand[11:8], 1'b0});
    else
      val2 = sh_res;
  end

  // Memory accesses always compute an address, so they force ADD.
  always_comb begin
    op     = mem_op ? 4'b0010 : exe_cmd;
    arith  = 1'b0;
    sub_op = 1'b0;
    ci     = 1'b0;
    case (op)
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; ci = status_q[1]; end
      4'b0100: begin arith = 1'b1; sub_op = 1'b1; ci = 1'b1; end
      4'b0101: begin
        arith  = 1'b1;
        sub_op = 1'b1;
        ci     = status_q[1];
      end
      default: ;
    endcase
    add_b = sub_op ? ~val2 : val2;
    sum   = {1'b0, op_a} + {1'b0, add_b} + {32'b0, ci};
    case (op)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0110: res = op_a & val2;
      4'b0111: res = op_a | val2;
      4'b1000: res = op_a ^ val2;
      4'b0010, 4'b0011,
      4'b0100, 4'b0101: res = sum[31:0];
      default: res = 32'b0;
    endcase
    flags[3] = res[31];
    flags[2] = ~|res;
    flags[1] = arith ? sum[32] : status_q[1];
    flags[0] = arith ? ((op_a[31] == add_b[31]) &&
                        (sum[31] != op_a[31]))
                     : status_q[0];
  end

  always_comb begin
    status_d = (s && !freeze) ? flags : status_q;
    alu_d    = freeze ? alu_q  : res;
    st_d     = freeze ? st_q   : rm_f;
    dest_d   = freeze ? dest_q : dest;
    wb_d     = freeze ? wb_q   : wb_en;
    mr_d     = freeze ? mr_q   : mem_r;
    mw_d     = freeze ? mw_q   : mem_w;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= 4'b0;
      alu_q    <= 32'b0;
      st_q     <= 32'b0;
      dest_q   <= 4'b0;
      wb_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
    end else begin
      status_q <= status_d;
      alu_q    <= alu_d;
      st_q     <= st_d;
      dest_q   <= dest_d;
      wb_q     <= wb_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
    end
  end

  assign status       = status_q;
  assign alu_res_out  = alu_q;
  assign st_val_out   = st_q;
  assign dest_out     = dest_q;
  assign wb_en_out    = wb_q;
  assign mem_r_out    = mr_q;
  assign mem_w_out    = mw_q;
  assign branch_taken = b;
  assign branch_addr  = pc + {{6{signed_imm[23]}}, signed_imm, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Random and directed bench for exe_stage against a
// behavioural model of the execute stage.
module tb_exe_stage;

  logic        clk = 1'b0, rst = 1'b0, freeze;
  logic [3:0]  exe_cmd, dest;
  logic        mem_r, mem_w, wb_en, imm, s, b;
  logic [31:0] val_rn, val_rm, pc, mem_fwd_val, wb_fwd_val;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [3:0]  status, dest_out;
  logic        branch_taken, wb_en_out, mem_r_out, mem_w_out;
  logic [31:0] branch_addr, alu_res_out, st_val_out;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  logic [3:0]  m_status = 0, m_dest = 0;
  logic [31:0] m_alu = 0, m_st = 0;
  logic        m_wb = 0, m_mr = 0, m_mw = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd),
    .mem_r(mem_r), .mem_w(mem_w), .wb_en(wb_en), .imm(imm),
    .s(s), .b(b), .dest(dest), .val_rn(val_rn), .val_rm(val_rm),
    .pc(pc), .shift_operand(shift_operand),
    .signed_imm(signed_imm), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .mem_fwd_val(mem_fwd_val),
    .wb_fwd_val(wb_fwd_val), .status(status),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .alu_res_out(alu_res_out), .st_val_out(st_val_out),
    .dest_out(dest_out), .wb_en_out(wb_en_out),
    .mem_r_out(mem_r_out), .mem_w_out(mem_w_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel,
    input logic [31:0] v, input logic [31:0] mv,
    input logic [31:0] wv);
    if (sel == 2'd1) return mv;
    if (sel == 2'd2) return wv;
    return v;
  endfunction

  // Shifts done one bit position at a time.
  function automatic logic [31:0] m_val2(input logic [31:0] rm);
    logic [31:0] r;
    int n;
    if (mem_r || mem_w) return {20'b0, shift_operand};
    if (imm) begin
      r = {24'b0, shift_operand[7:0]};
      n = 2 * int'(shift_operand[11:8]);
      for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      return r;
    end
    r = rm;
    n = int'(shift_operand[11:7]);
    for (int i = 0; i < n; i++)
      case (shift_operand[6:5])
        2'd0: r = {r[30:0], 1'b0};
        2'd1: r = {1'b0, r[31:1]};
        2'd2: r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin : mdl
    logic [31:0] a, rm, v2, r;
    logic [3:0]  op;
    longint ua, ub, sa, sb, u, sv;
    logic c, v, arith;
    int bi;
    if (!rst) begin
      m_status <= 0; m_alu <= 0; m_st <= 0; m_dest <= 0;
      m_wb <= 0; m_mr <= 0; m_mw <= 0;
    end else if (!freeze) begin
      a  = fwd(fwd_sel1, val_rn, mem_fwd_val, wb_fwd_val);
      rm = fwd(fwd_sel2, val_rm, mem_fwd_val, wb_fwd_val);
      v2 = m_val2(rm);
      op = (mem_r || mem_w) ? 4'd2 : exe_cmd;
      bi = int'(m_status[1]);
      c = m_status[1]; v = m_status[0]; arith = 0; r = 0;
      ua = a; ub = v2; sa = $signed(a); sb = $signed(v2);
      u = 0; sv = 0;
      case (op)
        4'd1: r = v2;
        4'd9: r = ~v2;
        4'd6: r = a & v2;
        4'd7: r = a | v2;
        4'd8: r = a ^ v2;
        4'd2, 4'd3: begin
          u  = ua + ub + ((op == 4'd3) ? bi : 0);
          sv = sa + sb + ((op == 4'd3) ? bi : 0);
          r = u[31:0]; c = u[32]; arith = 1;
        end
        4'd4, 4'd5: begin
          u  = ua - ub - ((op == 4'd5) ? 1 - bi : 0);
          sv = sa - sb - ((op == 4'd5) ? 1 - bi : 0);
          r = u[31:0]; c = (u >= 0); arith = 1;
        end
        default: r = 0;
      endcase
      if (arith)
        v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      if (s) m_status <= {r[31], r == 32'd0, c, v};
      m_alu <= r; m_st <= rm; m_dest <= dest;
      m_wb <= wb_en; m_mr <= mem_r; m_mw <= mem_w;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("cmp_alu", alu_res_out, m_alu);
    chk("cmp_st", st_val_out, m_st);
    chk("cmp_status", {28'b0, status}, {28'b0, m_status});
    chk("cmp_ctl", {25'b0, dest_out, wb_en_out, mem_r_out,
                    mem_w_out},
        {25'b0, m_dest, m_wb, m_mr, m_mw});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    freeze = 0; exe_cmd = 0; mem_r = 0; mem_w = 0; wb_en = 0;
    imm = 0; s = 0; b = 0; dest = 0; val_rn = 0; val_rm = 0;
    pc = 0; shift_operand = 0; signed_imm = 0; fwd_sel1 = 0;
    fwd_sel2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
  endtask

  task automatic chk_branch();
    longint o;
    logic [31:0] e;
    #1;
    o = signed_imm[23] ? longint'(signed_imm) - 16777216
                       : longint'(signed_imm);
    e = 32'(longint'(pc) + o * 4);
    chk("branch_addr", branch_addr, e);
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, b});
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_zero_all(input string nm);
    chk({nm, "_alu"}, alu_res_out, 0);
    chk({nm, "_st"}, st_val_out, 0);
    chk({nm, "_status"}, {28'b0, status}, 0);
    chk({nm, "_ctl"}, {25'b0, dest_out, wb_en_out, mem_r_out,
                       mem_w_out}, 0);
  endtask

  initial begin
    idle();
    repeat (2) tick();
    chk_zero_all("reset");
    rst = 1;
    chk_en = 1;

    exe_cmd = 4'b0010; s = 1; val_rn = 32'h7FFFFFFF;
    imm = 1; shift_operand = 12'h001;
    tick();
    chk("add_ovf_res", alu_res_out, 32'h80000000);
    chk("add_ovf_status", {28'b0, status}, 32'h9);

    exe_cmd = 4'b0100; val_rn = 5; shift_operand = 12'h005;
    tick();
    chk("sub_res", alu_res_out, 0);
    chk("sub_status", {28'b0, status}, 32'h6);
    exe_cmd = 4'b0101;
    tick();
    chk("sbc_res", alu_res_out, 0);

    s = 0; exe_cmd = 4'b0001; shift_operand = 12'h4FF;
    tick();
    chk("imm_rot", alu_res_out, 32'hFF000000);
    imm = 0; val_rm = 32'hF; shift_operand = 12'h260;
    tick();
    chk("reg_ror4", alu_res_out, 32'hF0000000);

    b = 1; pc = 32'h100; signed_imm = 24'hFFFFFE;
    #1;
    chk("br_lit_addr", branch_addr, 32'hF8);
    chk("br_lit_taken", {31'b0, branch_taken}, 1);
    b = 0;

    exe_cmd = 4'b0010; s = 1; imm = 1; shift_operand = 12'h001;
    fwd_sel1 = 2'b01; mem_fwd_val = 10; val_rn = 3;
    tick();
    chk("fwd_add", alu_res_out, 11);
    chk("fwd_status", {28'b0, status}, 0);
    freeze = 1; exe_cmd = 4'b0100; fwd_sel1 = 0; val_rn = 0;
    shift_operand = 12'h005; wb_en = 1; dest = 4'hA;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("frz_alu", alu_res_out, 11);
      chk("frz_status", {28'b0, status}, 0);
      chk("frz_wb", {31'b0, wb_en_out}, 0);
    end
    idle();

    for (int i = 0; i < 400; i++) begin
      tick();
      freeze = ($urandom_range(0, 5) == 0);
      exe_cmd = 4'($urandom_range(0, 15));
      mem_r = ($urandom_range(0, 7) == 0);
      mem_w = ($urandom_range(0, 7) == 0);
      wb_en = 1'($urandom); imm = 1'($urandom);
      s = 1'($urandom); b = 1'($urandom);
      dest = 4'($urandom);
      val_rn = rval(); val_rm = rval(); pc = $urandom;
      shift_operand = 12'($urandom);
      signed_imm = 24'($urandom);
      fwd_sel1 = 2'($urandom); fwd_sel2 = 2'($urandom);
      mem_fwd_val = rval(); wb_fwd_val = rval();
      chk_branch();
    end
    tick();
    idle();

    exe_cmd = 4'b0010; s = 1; val_rn = 32'h80000000;
    val_rm = 32'h1234; wb_en = 1; mem_w = 1; dest = 4'h7;
    tick();
    chk("pre_rst_alu", alu_res_out, 32'h80000000);
    freeze = 1;
    #2;
    rst = 0;
    #1;
    chk_zero_all("async_rst");
    tick();
    rst = 1;
    idle();
    tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port freeze, input, 1 bit: memory-stage stall; holds all internal state.
REQ-004 SHALL have port exe_cmd, input, 4 bits: ALU op (0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR).
REQ-005 SHALL have ports mem_r, mem_w, wb_en, imm, s, b, each input, 1 bit: decoded controls from the ID/EX register.
REQ-006 SHALL have port dest, input, 4 bits: destination register index.
REQ-007 SHALL have ports val_rn, val_rm, pc, each input, 32 bits: operand Rn, operand Rm, PC+4 of the instruction.
REQ-008 SHALL have port shift_operand, input, 12 bits; and port signed_imm, input, 24 bits: branch offset in words.
REQ-009 SHALL have ports fwd_sel1, fwd_sel2, each input, 2 bits: forwarding select for Rn and Rm (00 none, 01 mem_fwd_val, 10 wb_fwd_val, 11 treated as 00).
REQ-010 SHALL have ports mem_fwd_val, wb_fwd_val, each input, 32 bits: forwarded results.
REQ-011 SHALL have port status, output, 4 bits: {N,Z,C,V} status register, fed back to ID for condition checks.
REQ-012 SHALL have port branch_taken, output, 1 bit, combinational, equal to b; and port branch_addr, output, 32 bits, combinational.
REQ-013 SHALL have ports alu_res_out, st_val_out, each output, 32 bits, registered: ALU result and store data.
REQ-014 SHALL have port dest_out, output, 4 bits; and ports wb_en_out, mem_r_out, mem_w_out, each output, 1 bit, all registered.

Function
REQ-015 SHALL form op_a and rm_f through the forwarding muxes per fwd_sel1 and fwd_sel2 before any other use.
REQ-016 SHALL compute val2 as follows when mem_r|mem_w: zero-extended shift_operand[11:0].
REQ-017 SHALL compute val2 as follows when imm=1 and not memory: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
REQ-018 SHALL compute val2 as follows otherwise: rm_f shifted by shift_operand[11:7], type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); shift amount 0 SHALL yield rm_f unchanged.
REQ-019 SHALL compute the result as follows: MOV=val2, MVN=~val2, ADD=op_a+val2, ADC=op_a+val2+C, SUB=op_a+~val2+1, SBC=op_a+~val2+C, AND/ORR/EOR bitwise; mem_r|mem_w SHALL force ADD regardless of exe_cmd; undefined exe_cmd SHALL give result 0.
REQ-020 SHALL derive flags as N=result[31] and Z=(result==0); for arithmetic ops, C=33rd-bit carry-out and V=signed overflow; for MOV/MVN/logic ops, C and V SHALL be unchanged.
REQ-021 SHALL compute branch_addr as pc + (sign-extended signed_imm << 2), 32-bit wrap-around.
REQ-022 SHALL load status with the new flags on a rising edge when s=1 and freeze=0; otherwise status holds.
REQ-023 SHALL load the EX/MEM registers on a rising edge when freeze=0: alu_res_out<=result, st_val_out<=rm_f, dest/wb_en/mem_r/mem_w<=inputs; when freeze=1, all SHALL hold.
REQ-024 SHALL have a latency of one cycle from inputs to registered outputs; status updates in the same edge.
REQ-025 SHALL give freeze priority over s: a frozen cycle never updates status, even with s=1.
REQ-026 SHALL accept a bubble (all controls 0) and register wb_en_out=mem_r_out=mem_w_out=0.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear status, alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_out and mem_w_out to 0, independent of clk and freeze.
REQ-028 SHALL, on rst deassertion, load normally from the first rising edge with freeze=0; reset mid-freeze SHALL still clear.

Verification
REQ-029 SHALL verify: ADD, s=1, val_rn=0x7FFFFFFF, imm=1, shift_operand=0x001 -> alu_res_out=0x80000000, status=1001.
REQ-030 SHALL verify: SUB, s=1, val_rn=5, val2=5 -> alu_res_out=0, status=0110; next SBC 5-5 with C=1 -> result 0.
REQ-031 SHALL verify: imm=1, shift_operand=0x4FF -> val2=0xFF000000; register ROR by 4 of 0x0000000F -> 0xF0000000.
REQ-032 SHALL verify: b=1, pc=0x100, signed_imm=0xFFFFFE -> branch_taken=1, branch_addr=0xF8.
REQ-033 SHALL verify: fwd_sel1=01, mem_fwd_val=10, val_rn=3, ADD val2=1 -> 11; freeze=1 for 2 cycles -> outputs and status unchanged.
REQ-034 SHALL verify: rst low asynchronously mid-cycle with freeze=1 -> all registered outputs and status are 0 immediately.
